// File: rtl/ball_track_if.sv
// Handshake and status bundle between the VGA/detector side, ball_track_ctrl and game logic.
interface ball_track_if;
  logic        vga_vrequest;
  logic [15:0] red_pixel_h_index;
  logic [15:0] red_pixel_v_index;
  logic        capture_req;
  logic        release_req;
  logic        freeze_ram;
  logic        busy;
  logic        pos_valid;
  logic        pos_ready;
  logic [15:0] pos_h;
  logic [15:0] pos_v;
  logic        lost;
  logic [7:0]  drop_count;

  modport master (
    output vga_vrequest, red_pixel_h_index, red_pixel_v_index, capture_req, release_req,
    output pos_ready,
    input  freeze_ram, busy, pos_valid, pos_h, pos_v, lost, drop_count
  );

  modport slave (
    input  vga_vrequest, red_pixel_h_index, red_pixel_v_index, capture_req, release_req,
    input  pos_ready,
    output freeze_ram, busy, pos_valid, pos_h, pos_v, lost, drop_count
  );
endinterface

// File: rtl/ball_track_ctrl.sv
// Frame-synchronous detector RAM freeze sequencer and centroid qualifier/reporter.
// Optional EMA position smoothing is enabled by defining BTC_SMOOTH_EN.
module ball_track_ctrl #(
  parameter int unsigned H_MAX        = 640,
  parameter int unsigned V_MAX        = 480,
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned LOST_FRAMES  = 4,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input logic         clk,
  input logic         rst,
  ball_track_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArm     = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StHold    = 2'd3;

  localparam logic [16:0] HLimit    = 17'(H_MAX);
  localparam logic [16:0] VLimit    = 17'(V_MAX);
  localparam logic [15:0] HoldLoad  = 16'(HOLD_FRAMES);
  localparam logic [8:0]  LostLimit = 9'(LOST_FRAMES);

  if (LOST_FRAMES < 1 || LOST_FRAMES > 255) begin : g_bad_lost
    $error("ball_track_ctrl: LOST_FRAMES must be 1..255");
  end
  if (SMOOTH_SHIFT > 16) begin : g_bad_shift
    $error("ball_track_ctrl: SMOOTH_SHIFT must be 0..16");
  end

  logic        vreq_q;
  logic        frame_start, frame_end;
  logic [1:0]  state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        freeze_q, busy_q;
  logic [15:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  logic        pos_valid_q, pos_valid_d;
  logic        lost_q, lost_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;
  logic [7:0]  drop_q, drop_d;
  logic        sample_ok, new_pos, xfer;
  logic [15:0] new_h, new_v;

  assign frame_start = bus.vga_vrequest & ~vreq_q;
  assign frame_end   = ~bus.vga_vrequest & vreq_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.capture_req && !bus.release_req) state_d = StArm;
      end
      StArm: begin
        if (bus.release_req)    state_d = StIdle;
        else if (frame_start)   state_d = StCapture;
      end
      StCapture: begin
        if (bus.release_req) begin
          state_d = StIdle;
        end else if (frame_end) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end
      end
      StHold: begin
        // A zero load means hold indefinitely, so the counter never moves.
        if (bus.release_req) begin
          state_d = StIdle;
        end else if (frame_end && HoldLoad != 16'd0) begin
          if (hold_cnt_q == 16'd1) state_d = StIdle;
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sample_ok = ({1'b0, bus.red_pixel_h_index} < HLimit) &&
                     ({1'b0, bus.red_pixel_v_index} < VLimit) &&
                     ((bus.red_pixel_h_index | bus.red_pixel_v_index) != 16'd0);
  assign new_pos   = frame_end && sample_ok;
  assign xfer      = pos_valid_q && bus.pos_ready;

`ifdef BTC_SMOOTH_EN
  logic have_pos_q;

  function automatic logic [15:0] ema(input logic [15:0] cur, input logic [15:0] nxt);
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    diff = $signed({1'b0, nxt}) - $signed({1'b0, cur});
    step = diff >>> SMOOTH_SHIFT;
    sum  = $signed({1'b0, cur}) + step;
    return sum[15:0];
  endfunction

  // First sample ever, or first after losing the target, snaps straight to the new position.
  always_comb begin
    if (!have_pos_q || lost_q) begin
      new_h = bus.red_pixel_h_index;
      new_v = bus.red_pixel_v_index;
    end else begin
      new_h = ema(pos_h_q, bus.red_pixel_h_index);
      new_v = ema(pos_v_q, bus.red_pixel_v_index);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          have_pos_q <= 1'b0;
    else if (new_pos) have_pos_q <= 1'b1;
  end
`else
  assign new_h = bus.red_pixel_h_index;
  assign new_v = bus.red_pixel_v_index;
`endif

  always_comb begin
    pos_h_d     = pos_h_q;
    pos_v_d     = pos_v_q;
    lost_d      = lost_q;
    lost_cnt_d  = lost_cnt_q;
    drop_d      = drop_q;
    pos_valid_d = new_pos | (pos_valid_q & ~xfer);
    if (frame_end) begin
      if (sample_ok) begin
        pos_h_d    = new_h;
        pos_v_d    = new_v;
        lost_cnt_d = 8'd0;
        lost_d     = 1'b0;
        if (pos_valid_q && !xfer && drop_q != 8'hff) drop_d = drop_q + 8'd1;
      end else begin
        if (lost_cnt_q != 8'hff) lost_cnt_d = lost_cnt_q + 8'd1;
        if (({1'b0, lost_cnt_q} + 9'd1) >= LostLimit) lost_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vreq_q      <= 1'b0;
      state_q     <= StIdle;
      hold_cnt_q  <= 16'd0;
      freeze_q    <= 1'b0;
      busy_q      <= 1'b0;
      pos_h_q     <= 16'd0;
      pos_v_q     <= 16'd0;
      pos_valid_q <= 1'b0;
      lost_q      <= 1'b0;
      lost_cnt_q  <= 8'd0;
      drop_q      <= 8'd0;
    end else begin
      vreq_q      <= bus.vga_vrequest;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      freeze_q    <= (state_d == StHold);
      busy_q      <= (state_d != StIdle);
      pos_h_q     <= pos_h_d;
      pos_v_q     <= pos_v_d;
      pos_valid_q <= pos_valid_d;
      lost_q      <= lost_d;
      lost_cnt_q  <= lost_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.freeze_ram = freeze_q;
  assign bus.busy       = busy_q;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.pos_h      = pos_h_q;
  assign bus.pos_v      = pos_v_q;
  assign bus.lost       = lost_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_ball_track_ctrl.sv
// Directed bench for ball_track_ctrl: two instances (hold 2 frames / hold until release).
module tb_ball_track_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vreq = 1'b1;
  logic [15:0] ch = 16'd100;
  logic [15:0] cv = 16'd200;
  logic        cap = 1'b0;
  logic        rel = 1'b0;
  logic        rdy = 1'b1;

  ball_track_if bus_a ();
  ball_track_if bus_b ();

  assign bus_a.vga_vrequest = vreq;
  assign bus_a.red_pixel_h_index = ch;
  assign bus_a.red_pixel_v_index = cv;
  assign bus_a.capture_req = cap;
  assign bus_a.release_req = rel;
  assign bus_a.pos_ready = rdy;
  assign bus_b.vga_vrequest = vreq;
  assign bus_b.red_pixel_h_index = ch;
  assign bus_b.red_pixel_v_index = cv;
  assign bus_b.capture_req = cap;
  assign bus_b.release_req = rel;
  assign bus_b.pos_ready = rdy;

  ball_track_ctrl #(.HOLD_FRAMES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ball_track_ctrl #(.HOLD_FRAMES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard of {h, v} results expected at the next transfer
  logic [31:0] sb_q[$];
  logic [15:0] m_h = 16'd0, m_v = 16'd0;
  bit          m_have = 1'b0, m_lost = 1'b0, m_pending = 1'b0;
  int          m_lost_cnt = 0, m_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_ema(input logic [15:0] cur, input logic [15:0] nxt);
    int d;
    d = int'(nxt) - int'(cur);
    d = d >>> 2;
    return 16'(int'(cur) + d);
  endfunction

  // Called in the cycle where the frame ends (vreq just dropped).
  task automatic model_sample(input logic [15:0] h, input logic [15:0] v);
    if (h < 16'd640 && v < 16'd480 && !(h == 16'd0 && v == 16'd0)) begin
`ifdef BTC_SMOOTH_EN
      if (!m_have || m_lost) begin
        m_h = h; m_v = v;
      end else begin
        m_h = model_ema(m_h, h); m_v = model_ema(m_v, v);
      end
`else
      m_h = h; m_v = v;
`endif
      m_have = 1'b1;
      m_lost = 1'b0;
      m_lost_cnt = 0;
      if (m_pending) begin
        if (m_drop < 255) m_drop++;
        void'(sb_q.pop_back());
      end
      sb_q.push_back({m_h, m_v});
      m_pending = !rdy;
    end else begin
      if (m_lost_cnt < 255) m_lost_cnt++;
      if (m_lost_cnt >= 4) m_lost = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_a.pos_valid && rdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("xfer_pos_h", {16'd0, bus_a.pos_h}, {16'd0, e[31:16]});
        check("xfer_pos_v", {16'd0, bus_a.pos_v}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input logic [15:0] h, input logic [15:0] v, input bit do_cap);
    tick(); vreq = 1'b1; ch = h; cv = v;
    tick(); cap = do_cap;
    tick(); cap = 1'b0;
    tick();
    tick(); vreq = 1'b0; model_sample(h, v);
    tick(); tick(); tick();
    check("frame_lost", {31'd0, bus_a.lost}, {31'd0, m_lost});
    check("frame_drop", {24'd0, bus_a.drop_count}, 32'(m_drop));
  endtask

  initial begin
    // Reset with vreq high; centroid already present
    repeat (3) tick();
    check("rst_freeze", {31'd0, bus_a.freeze_ram}, 32'd0);
    check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst_valid", {31'd0, bus_a.pos_valid}, 32'd0);
    check("rst_lost", {31'd0, bus_a.lost}, 32'd0);
    check("rst_drop", {24'd0, bus_a.drop_count}, 32'd0);
    check("rst_pos_h", {16'd0, bus_a.pos_h}, 32'd0);
    check("rst_freeze_b", {31'd0, bus_b.freeze_ram}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("no_early_valid", {31'd0, bus_a.pos_valid}, 32'd0);
    vreq = 1'b0; model_sample(16'd100, 16'd200);
    tick();
    check("first_valid", {31'd0, bus_a.pos_valid}, 32'd1);
    check("first_pos_h", {16'd0, bus_a.pos_h}, 32'd100);
    check("first_pos_v", {16'd0, bus_a.pos_v}, 32'd200);
    check("first_freeze", {31'd0, bus_a.freeze_ram}, 32'd0);
    tick();
    check("valid_pulse_end", {31'd0, bus_a.pos_valid}, 32'd0);
    tick(); tick();

    // Capture mid-frame: ARM, CAPTURE next frame, then HOLD for 2 frame ends
    run_frame(16'd10, 16'd20, 1'b1);
    check("arm_busy", {31'd0, bus_a.busy}, 32'd1);
    check("arm_freeze", {31'd0, bus_a.freeze_ram}, 32'd0);
    run_frame(16'd11, 16'd21, 1'b0);
    check("hold1_freeze", {31'd0, bus_a.freeze_ram}, 32'd1);
    run_frame(16'd12, 16'd22, 1'b0);
    check("hold2_freeze", {31'd0, bus_a.freeze_ram}, 32'd1);
    run_frame(16'd13, 16'd23, 1'b0);
    check("hold_done_freeze", {31'd0, bus_a.freeze_ram}, 32'd0);
    check("hold_done_busy", {31'd0, bus_a.busy}, 32'd0);

    // HOLD_FRAMES=0 instance holds until release
    for (int i = 0; i < 10; i++) run_frame(16'(30 + i), 16'(40 + i), 1'b0);
    check("inf_hold_freeze", {31'd0, bus_b.freeze_ram}, 32'd1);
    check("inf_hold_busy", {31'd0, bus_b.busy}, 32'd1);
    rel = 1'b1;
    tick();
    check("release_freeze", {31'd0, bus_b.freeze_ram}, 32'd0);
    check("release_busy", {31'd0, bus_b.busy}, 32'd0);
    rel = 1'b0;

    // Boundaries: last valid pixel, then out-of-range column counts as lost
    run_frame(16'd639, 16'd479, 1'b0);
    check("edge_pos_h", {16'd0, bus_a.pos_h}, {16'd0, m_h});
    run_frame(16'd640, 16'd10, 1'b0);
    run_frame(16'd10, 16'd480, 1'b0);

    // Lost detection
    for (int i = 0; i < 4; i++) begin
      run_frame(16'd0, 16'd0, 1'b0);
      check("lost_no_valid", {31'd0, bus_a.pos_valid}, 32'd0);
    end
    check("lost_set", {31'd0, bus_a.lost}, 32'd1);
    run_frame(16'd50, 16'd60, 1'b0);
    check("reacq_lost", {31'd0, bus_a.lost}, 32'd0);
    check("reacq_pos_h", {16'd0, bus_a.pos_h}, 32'd50);
    check("reacq_pos_v", {16'd0, bus_a.pos_v}, 32'd60);

    // Backpressure: overwrites count as drops, latest wins
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) run_frame(16'(70 + i), 16'(80 + i), 1'b0);
    check("drop3_count", {24'd0, bus_a.drop_count}, 32'd2);
    check("drop3_valid", {31'd0, bus_a.pos_valid}, 32'd1);
    check("drop3_pos_h", {16'd0, bus_a.pos_h}, {16'd0, m_h});
    check("drop3_pos_v", {16'd0, bus_a.pos_v}, {16'd0, m_v});
    for (int i = 3; i < 300; i++) run_frame(16'(100 + i), 16'(i), 1'b0);
    check("drop_saturate", {24'd0, bus_a.drop_count}, 32'd255);
    rdy = 1'b1; m_pending = 1'b0;
    tick();
    check("drain_valid", {31'd0, bus_a.pos_valid}, 32'd0);
    check("drain_queue", 32'(sb_q.size()), 32'd0);

    // Smoothing: lose target first so the next sample loads directly
    for (int i = 0; i < 4; i++) run_frame(16'd0, 16'd0, 1'b0);
    run_frame(16'h40, 16'd5, 1'b0);
    check("smooth_first", {16'd0, bus_a.pos_h}, 32'h40);
    run_frame(16'h80, 16'd5, 1'b0);
`ifdef BTC_SMOOTH_EN
    check("smooth_second", {16'd0, bus_a.pos_h}, 32'h50);
`else
    check("smooth_second", {16'd0, bus_a.pos_h}, 32'h80);
`endif
    tick(); tick();
    check("final_queue", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
